// File: rtl/any1_pkg.sv
`default_nettype none
// ============================================================================
// Module   : any1_pkg
// Purpose  : Shared ANY-1 ROB entry types and issue-stage constants.
// Revision : 1.0
// ============================================================================
package any1_pkg;

    localparam int ROB_ENTRIES = 64;

    // Scheduler "no selection" code; also the idle value of the pexec feedback.
    localparam logic [6:0] NO_SEL = 7'h7F;

    typedef struct packed {
        logic        v;
        logic        out;
        logic        executed;
        logic [5:0]  rid;
        logic [31:0] pc;
        logic [31:0] ir;
    } sReorderEntry;

    typedef struct packed {
        logic         v;
        sReorderEntry e;
    } sIssueSlot;

endpackage
`default_nettype wire

// File: rtl/any1_skid_buf.sv
`default_nettype none
// ============================================================================
// Module   : any1_skid_buf
// Purpose  : Generic two-slot valid/ready buffer; A is the output register,
//            B the skid register. Ordering is strictly preserved.
// Revision : 1.0
// ============================================================================
module any1_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_v,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_rdy,
    output logic             o_v,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_rdy,
    output logic             o_b_v,
    output logic [WIDTH-1:0] o_b_data
);

    logic             r_a_v;
    logic             r_b_v;
    logic [WIDTH-1:0] r_a_data;
    logic [WIDTH-1:0] r_b_data;
    logic             w_push;
    logic             w_pop;

    // Ready depends only on B so there is no combinational path from i_rdy.
    assign w_push = i_v & ~r_b_v;
    assign w_pop  = r_a_v & i_rdy;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_a_v    <= 1'b0;
            r_b_v    <= 1'b0;
            r_a_data <= '0;
            r_b_data <= '0;
        end else if (w_pop) begin
            if (r_b_v) begin
                r_a_data <= r_b_data;
                r_b_v    <= 1'b0;
            end else if (w_push) begin
                r_a_data <= i_data;
            end else begin
                r_a_v    <= 1'b0;
            end
        end else if (w_push) begin
            if (!r_a_v) begin
                r_a_v    <= 1'b1;
                r_a_data <= i_data;
            end else begin
                r_b_v    <= 1'b1;
                r_b_data <= i_data;
            end
        end
    end

    assign o_rdy    = ~r_b_v;
    assign o_v      = r_a_v;
    assign o_data   = r_a_data;
    assign o_b_v    = r_b_v;
    assign o_b_data = r_b_data;

endmodule
`default_nettype wire

// File: rtl/any1_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : any1_issue_stage
// Purpose  : Captures the scheduler's ROB pick, marks it out, and presents it
//            to the execution unit; adds a stall watchdog and issue counter.
// Revision : 1.0
// ============================================================================
module any1_issue_stage
    import any1_pkg::*;
#(
    parameter int STALL_LIMIT = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         flush_i,
    input  sReorderEntry rob_i [ROB_ENTRIES],
    input  logic [6:0]   selection_i,
    output logic         issue_rdy_o,
    output logic         out_set_o,
    output logic [5:0]   out_rid_o,
    output logic [6:0]   rob_pexec_o,
    output logic [6:0]   rob_pexec2_o,
    output logic         ex_v_o,
    input  logic         ex_rdy_i,
    output sReorderEntry ex_o,
    output logic         stall_o,
    output logic [31:0]  issued_cnt_o
);

    localparam int          c_entry_w     = $bits(sReorderEntry);
    localparam logic [15:0] c_stall_limit = 16'(STALL_LIMIT);

    logic [5:0]           w_idx;
    sReorderEntry         w_snap;
    logic                 w_accept;
    logic                 w_drain;
    logic                 w_buf_rdy;
    logic                 w_a_v;
    logic                 w_b_v;
    logic [c_entry_w-1:0] w_a_data;
    logic [c_entry_w-1:0] w_b_data;
    sIssueSlot            w_slot_a;
    sIssueSlot            w_slot_b;
    logic [15:0]          r_wd_cnt;
    logic [31:0]          r_issued_cnt;

    assign w_idx = selection_i[5:0];

    // Snapshot the selected ROB entry; rid is forced so it always names its slot.
    always_comb begin
        w_snap     = rob_i[w_idx];
        w_snap.rid = w_idx;
    end

    assign w_accept = w_buf_rdy & ~selection_i[6] & ~flush_i & rob_i[w_idx].v;
    assign w_drain  = w_a_v & ex_rdy_i;

    any1_skid_buf #(
        .WIDTH (c_entry_w)
    ) u_skid (
        .clk      (clk_i),
        .rst      (rst_i),
        .i_flush  (flush_i),
        .i_v      (w_accept),
        .i_data   (w_snap),
        .o_rdy    (w_buf_rdy),
        .o_v      (w_a_v),
        .o_data   (w_a_data),
        .i_rdy    (ex_rdy_i),
        .o_b_v    (w_b_v),
        .o_b_data (w_b_data)
    );

    assign w_slot_a = '{v: w_a_v, e: sReorderEntry'(w_a_data)};
    assign w_slot_b = '{v: w_b_v, e: sReorderEntry'(w_b_data)};

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i || w_drain) begin
            r_wd_cnt <= '0;
        end else if (w_a_v && !ex_rdy_i && r_wd_cnt != c_stall_limit) begin
            r_wd_cnt <= r_wd_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_issued_cnt <= '0;
        end else if (w_accept) begin
            r_issued_cnt <= r_issued_cnt + 32'd1;
        end
    end

    assign issue_rdy_o  = w_buf_rdy;
    assign out_set_o    = w_accept;
    assign out_rid_o    = w_idx;
    // Empty slots report NO_SEL so the scheduler never matches a stale rid.
    assign rob_pexec_o  = w_slot_a.v ? {1'b0, w_slot_a.e.rid} : NO_SEL;
    assign rob_pexec2_o = w_slot_b.v ? {1'b0, w_slot_b.e.rid} : NO_SEL;
    assign ex_v_o       = w_slot_a.v;
    assign ex_o         = w_slot_a.e;
    assign stall_o      = (r_wd_cnt == c_stall_limit);
    assign issued_cnt_o = r_issued_cnt;

endmodule
`default_nettype wire

// File: tb/tb_any1_issue_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_any1_issue_stage
// Purpose  : Directed self-checking bench with an in-order expected-rid queue.
// Revision : 1.0
// ============================================================================
module tb_any1_issue_stage;
    import any1_pkg::*;

    logic         clk;
    logic         rst_i;
    logic         flush_i;
    sReorderEntry rob [ROB_ENTRIES];
    logic [6:0]   selection_i;
    logic         issue_rdy_o;
    logic         out_set_o;
    logic [5:0]   out_rid_o;
    logic [6:0]   rob_pexec_o;
    logic [6:0]   rob_pexec2_o;
    logic         ex_v_o;
    logic         ex_rdy_i;
    sReorderEntry ex_o;
    logic         stall_o;
    logic [31:0]  issued_cnt_o;

    int checks = 0;
    int errors = 0;
    int unsigned exp_q [$];
    int unsigned mon_exp;

    any1_issue_stage #(.STALL_LIMIT(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .flush_i      (flush_i),
        .rob_i        (rob),
        .selection_i  (selection_i),
        .issue_rdy_o  (issue_rdy_o),
        .out_set_o    (out_set_o),
        .out_rid_o    (out_rid_o),
        .rob_pexec_o  (rob_pexec_o),
        .rob_pexec2_o (rob_pexec2_o),
        .ex_v_o       (ex_v_o),
        .ex_rdy_i     (ex_rdy_i),
        .ex_o         (ex_o),
        .stall_o      (stall_o),
        .issued_cnt_o (issued_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // Every drain pops the oldest expected rid and checks the presented entry.
    always @(negedge clk) begin
        if (!rst_i && ex_v_o && ex_rdy_i) begin
            if (exp_q.size() == 0) begin
                check("drain_unexpected", 64'(ex_o.rid), 64'hFF);
            end else begin
                mon_exp = exp_q.pop_front();
                check("drain_rid", 64'(ex_o.rid), 64'(mon_exp));
                check("drain_pc",  64'(ex_o.pc), 64'(32'h1000 + mon_exp * 4));
            end
        end
    end

    initial begin
        for (int i = 0; i < ROB_ENTRIES; i++) begin
            rob[i].v        = (i != 9);
            rob[i].out      = 1'b0;
            rob[i].executed = 1'b0;
            rob[i].rid      = 6'(63 - i);
            rob[i].pc       = 32'h1000 + 32'(i) * 4;
            rob[i].ir       = 32'(i) ^ 32'hA5A5_0000;
        end
        rst_i = 1'b1; flush_i = 1'b0; selection_i = NO_SEL; ex_rdy_i = 1'b1;
        cyc(); cyc();
        rst_i = 1'b0;
        samp();
        check("rst_ex_v",      64'(ex_v_o), 0);
        check("rst_issue_rdy", 64'(issue_rdy_o), 1);
        check("rst_pexec",     64'(rob_pexec_o), 64'h7F);
        check("rst_pexec2",    64'(rob_pexec2_o), 64'h7F);
        check("rst_stall",     64'(stall_o), 0);
        check("rst_issued",    64'(issued_cnt_o), 0);
        check("rst_out_set",   64'(out_set_o), 0);
        check("rst_ex_o_zero", 64'(ex_o === '0), 1);
        cyc();

        // Single issue into an empty stage
        selection_i = 7'd5;
        samp();
        check("t1_out_set", 64'(out_set_o), 1);
        check("t1_out_rid", 64'(out_rid_o), 5);
        exp_q.push_back(5);
        cyc();
        selection_i = NO_SEL;
        samp();
        check("t1_ex_v",   64'(ex_v_o), 1);
        check("t1_pexec",  64'(rob_pexec_o), 64'h05);
        check("t1_issued", 64'(issued_cnt_o), 1);
        cyc();
        samp();
        check("t1_empty", 64'(ex_v_o), 0);
        cyc();

        // Back-pressure fills A then B; third selection dropped
        ex_rdy_i = 1'b0; selection_i = 7'd3;
        samp();
        check("t2_acc3", 64'(out_set_o), 1);
        exp_q.push_back(3);
        cyc();
        selection_i = 7'd4;
        samp();
        check("t2_acc4",   64'(out_set_o), 1);
        check("t2_pexec3", 64'(rob_pexec_o), 64'h03);
        exp_q.push_back(4);
        cyc();
        selection_i = 7'd7;
        samp();
        check("t2_full_rdy", 64'(issue_rdy_o), 0);
        check("t2_drop7",    64'(out_set_o), 0);
        check("t2_pexec2_4", 64'(rob_pexec2_o), 64'h04);
        check("t2_hold_a",   64'(ex_o.rid), 3);
        cyc();
        selection_i = NO_SEL; ex_rdy_i = 1'b1;
        samp();
        cyc();
        samp();
        check("t2_pexec_4",  64'(rob_pexec_o), 64'h04);
        check("t2_pexec2_f", 64'(rob_pexec2_o), 64'h7F);
        check("t2_rdy_back", 64'(issue_rdy_o), 1);
        check("t2_issued",   64'(issued_cnt_o), 3);
        cyc();
        samp();
        check("t2_empty", 64'(ex_v_o), 0);
        cyc();

        // Accept and drain in the same cycle with only A valid
        ex_rdy_i = 1'b0; selection_i = 7'd10;
        samp();
        check("t3_acc10", 64'(out_set_o), 1);
        exp_q.push_back(10);
        cyc();
        selection_i = 7'd11; ex_rdy_i = 1'b1;
        samp();
        check("t3_acc11", 64'(out_set_o), 1);
        exp_q.push_back(11);
        cyc();

        // Watchdog with STALL_LIMIT = 4
        selection_i = NO_SEL; ex_rdy_i = 1'b0;
        samp();
        check("t3_ex_v",   64'(ex_v_o), 1);
        check("t3_pexec",  64'(rob_pexec_o), 64'h0B);
        check("t3_pexec2", 64'(rob_pexec2_o), 64'h7F);
        check("t3_rdy",    64'(issue_rdy_o), 1);
        check("t4_stall0", 64'(stall_o), 0);
        cyc();
        for (int i = 0; i < 3; i++) begin
            samp();
            check("t4_stall_low", 64'(stall_o), 0);
            check("t4_stable",    64'(ex_o.rid), 11);
            cyc();
        end
        samp();
        check("t4_stall_high", 64'(stall_o), 1);
        cyc();
        ex_rdy_i = 1'b1;
        samp();
        check("t4_stall_sat", 64'(stall_o), 1);
        cyc();
        ex_rdy_i = 1'b0;
        samp();
        check("t4_stall_clr", 64'(stall_o), 0);
        check("t4_empty",     64'(ex_v_o), 0);
        cyc();

        // Flush with both slots full and a selection offered
        selection_i = 7'd20;
        samp();
        check("t5_acc20", 64'(out_set_o), 1);
        exp_q.push_back(20);
        cyc();
        selection_i = 7'd21;
        samp();
        check("t5_acc21", 64'(out_set_o), 1);
        exp_q.push_back(21);
        cyc();
        selection_i = 7'd22; flush_i = 1'b1;
        samp();
        check("t5_flush_out_set", 64'(out_set_o), 0);
        cyc();
        exp_q.delete();
        flush_i = 1'b0; selection_i = NO_SEL;
        samp();
        check("t5_ex_v",   64'(ex_v_o), 0);
        check("t5_pexec",  64'(rob_pexec_o), 64'h7F);
        check("t5_pexec2", 64'(rob_pexec2_o), 64'h7F);
        check("t5_rdy",    64'(issue_rdy_o), 1);
        check("t5_issued", 64'(issued_cnt_o), 7);
        check("t5_stall",  64'(stall_o), 0);
        cyc();

        // Non-accepting selections
        selection_i = 7'h7F;
        samp();
        check("t6_none63", 64'(out_set_o), 0);
        cyc();
        selection_i = 7'h45;
        samp();
        check("t6_none5", 64'(out_set_o), 0);
        cyc();
        selection_i = 7'd9;
        samp();
        check("t6_invalid9", 64'(out_set_o), 0);
        cyc();
        selection_i = NO_SEL;
        samp();
        check("t6_issued", 64'(issued_cnt_o), 7);
        check("t6_ex_v",   64'(ex_v_o), 0);
        cyc();

        // Full throughput
        ex_rdy_i = 1'b1;
        for (int i = 30; i < 34; i++) begin
            selection_i = 7'(i);
            samp();
            check("t7_acc", 64'(out_set_o), 1);
            exp_q.push_back(i);
            cyc();
        end
        selection_i = NO_SEL;
        samp();
        cyc();
        samp();
        check("t7_empty",  64'(ex_v_o), 0);
        check("t7_issued", 64'(issued_cnt_o), 11);
        cyc();

        // Reset during operation
        ex_rdy_i = 1'b0; selection_i = 7'd40;
        samp();
        check("t8_acc40", 64'(out_set_o), 1);
        exp_q.push_back(40);
        cyc();
        selection_i = NO_SEL; rst_i = 1'b1;
        samp();
        cyc();
        exp_q.delete();
        rst_i = 1'b0;
        samp();
        check("t8_ex_v",   64'(ex_v_o), 0);
        check("t8_pexec",  64'(rob_pexec_o), 64'h7F);
        check("t8_issued", 64'(issued_cnt_o), 0);
        cyc();

        check("queue_empty", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
